aes_rcon_round_ctrl: RTL and testbench
======================================

Name: aes_rcon_round_ctrl

Overview:
- Round/column sequencer for the masked AES-128 encrypt/decrypt core with a 32-bit datapath.
- Accepts a job through a valid/ready handshake and steps through NR rounds of CPR column cycles each.
- Drives the round-constant generator: init pulse, update strobe, output gating and direction.
- Signals completion through a valid/ready output handshake.

Parameters:
- NR, 10, number of rounds per job (AES-128).
- CPR, 4, datapath cycles per round (32-bit columns).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  job request.
- in_ready  output  1  controller can accept a job; high only in IDLE.
- in_inverse  input  1  direction of the job (1 = decrypt); sampled on accept.
- out_valid  output  1  job finished; held until out_ready.
- out_ready  input  1  consumer accepts the finished job.
- rcon_init  output  1  loads the rcon generator's start value.
- rcon_update  output  1  advances rcon by one step.
- rcon_mask  output  1  ungates the rcon sharing (1 = rcon value, 0 = zero).
- rcon_inverse  output  1  direction to the rcon generator; latched copy of in_inverse.
- round_idx  output  4  current round, 0..NR-1.
- col_idx  output  2  current column, 0..CPR-1.
- last_round  output  1  high while round_idx == NR-1 in ROUND.
- busy  output  1  high in INIT and ROUND.

Behaviour:
- States: IDLE, INIT, ROUND, DONE. Registered state; all outputs decoded from registered state and counters (Moore).
- Reset (rst=1 at an edge): state=IDLE, round_idx=0, col_idx=0, rcon_inverse=0.
  - Required output values while in reset-induced IDLE: in_ready=1, out_valid=0, busy=0, rcon_update=0, rcon_mask=0, last_round=0.
  - rcon_init=1 while rst is high, so the generator is reset in the same cycle.
  - rst overrides every event, including mid-job and a simultaneous in_valid.
- IDLE: in_ready=1. On in_valid: latch in_inverse into rcon_inverse, go to INIT. A new job is accepted only in IDLE; in_valid in any other state is ignored with in_ready=0.
- INIT: exactly one cycle. rcon_init=1 so the generator loads 0x01 (forward) or its inverse start value. Clear both counters, go to ROUND.
- ROUND:
  - col_idx counts 0..CPR-1, then wraps to 0 and increments round_idx.
  - rcon_mask=1 only when col_idx==0; 0 in all other columns and in all other states.
  - rcon_update=1 when col_idx==CPR-1 and round_idx<NR-1, so the next round's column 0 sees the new constant. No update in the final round, so rcon is never advanced past round NR-1.
  - When round_idx==NR-1 and col_idx==CPR-1: go to DONE.
  - ROUND lasts exactly NR*CPR cycles (40 at defaults).
- DONE: out_valid=1 until the cycle where out_ready=1, then go to IDLE. out_valid does not depend combinationally on out_ready. If out_ready is already high on DONE entry, DONE lasts one cycle.
- Latency: accept edge to first out_valid cycle is 1 + NR*CPR + 1 cycles (42 at defaults).
- Counter widths: round_idx 4 bits, col_idx 2 bits. NR<=16 and CPR<=4 are legal; elaboration fails otherwise.

Optional Feature:
- Macro: AES_RCON_CTRL_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in INIT, ROUND or DONE returns to IDLE at the next edge with:
  - counters cleared;
  - out_valid=0 (no out_valid pulse for the aborted job);
  - rcon_init=1 during the abort cycle.
  - abort has no effect in IDLE. rst has priority over abort.
- Undefined: no abort port; jobs always run to DONE.

Test Plan:
- Forward job: rst then in_valid=1, in_inverse=0 -> INIT 1 cycle; rcon_mask high on 10 cycles (col 0 of rounds 0..9); rcon_update high on 9 cycles; with out_ready=1, out_valid high at cycle 42 after accept; generator values seen 0x01,0x02,...,0x80,0x1b,0x36.
- Inverse job: in_inverse=1 -> rcon_inverse=1 throughout; same mask/update timing; generator values follow the inverse sequence from its inverse start value.
- Backpressure: out_ready=0 for 5 cycles after DONE entry -> out_valid held 6 cycles, in_ready=0; out_ready=1 -> IDLE next edge.
- Busy rejection: in_valid pulsed at rounds 3 and in DONE -> ignored; exactly one out_valid for the original job.
- Reset mid-job: rst at round 5, col 2 -> IDLE next edge, rcon_init=1, out_valid never asserts; following job completes normally from 0x01.
- With AES_RCON_CTRL_ABORT_EN: abort at round 7 -> IDLE, no out_valid; abort and rst together -> reset behaviour.

Source files
------------

// File: rtl/aes_rcon_round_ctrl.sv
// aes_rcon_round_ctrl
// Round/column sequencer for a masked AES-128 core with a 32-bit datapath.
// A job is accepted over a valid/ready handshake. The controller then runs
// NR rounds of CPR column cycles each and steers the round-constant
// generator. Completion is reported over a valid/ready output handshake.
//
// Optional feature: define AES_RCON_CTRL_ABORT_EN to add the `abort` input.
// It returns any active job to IDLE without producing an out_valid.
//
// Ports:
//   clk, rst      - clock; synchronous active-high reset
//   in_valid      - job request (accepted only in IDLE)
//   in_ready      - high only in IDLE
//   in_inverse    - job direction (1 = decrypt), latched on accept
//   out_valid     - job finished, held until out_ready
//   out_ready     - consumer takes the finished job
//   abort         - (AES_RCON_CTRL_ABORT_EN only) cancel the running job
//   rcon_init     - load the rcon generator start value
//   rcon_update   - advance the rcon generator one step
//   rcon_mask     - ungate the rcon share (column 0 of each round)
//   rcon_inverse  - latched direction for the rcon generator
//   round_idx     - current round 0..NR-1
//   col_idx       - current column 0..CPR-1
//   last_round    - round_idx == NR-1 while in ROUND
//   busy          - high in INIT and ROUND
module aes_rcon_round_ctrl #(
  parameter int NR  = 10,
  parameter int CPR = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_inverse,
  output logic       out_valid,
  input  logic       out_ready,
`ifdef AES_RCON_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       rcon_init,
  output logic       rcon_update,
  output logic       rcon_mask,
  output logic       rcon_inverse,
  output logic [3:0] round_idx,
  output logic [1:0] col_idx,
  output logic       last_round,
  output logic       busy
);

  generate
    if (NR < 1 || NR > 16 || CPR < 1 || CPR > 4) begin : g_bad_params
      $error("aes_rcon_round_ctrl: NR must be 1..16 and CPR must be 1..4");
    end
  endgenerate

  localparam logic [3:0] ROUND_LAST = 4'(NR - 1);
  localparam logic [1:0] COL_LAST   = 2'(CPR - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state, state_next;
  logic [3:0] round_next;
  logic [1:0] col_next;
  logic       inv_next;
  logic       abort_req;

`ifdef AES_RCON_CTRL_ABORT_EN
  // Abort only matters once a job has been accepted.
  assign abort_req = abort && (state != S_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      round_idx    <= 4'd0;
      col_idx      <= 2'd0;
      rcon_inverse <= 1'b0;
    end else begin
      state        <= state_next;
      round_idx    <= round_next;
      col_idx      <= col_next;
      rcon_inverse <= inv_next;
    end
  end

  always_comb begin
    state_next = state;
    round_next = round_idx;
    col_next   = col_idx;
    inv_next   = rcon_inverse;
    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          inv_next   = in_inverse;
          state_next = S_INIT;
        end
      end
      S_INIT: begin
        round_next = 4'd0;
        col_next   = 2'd0;
        state_next = S_ROUND;
      end
      S_ROUND: begin
        if (col_idx == COL_LAST) begin
          col_next = 2'd0;
          if (round_idx == ROUND_LAST) begin
            // Counters are parked at zero outside ROUND.
            round_next = 4'd0;
            state_next = S_DONE;
          end else begin
            round_next = round_idx + 4'd1;
          end
        end else begin
          col_next = col_idx + 2'd1;
        end
      end
      S_DONE: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (abort_req) begin
      state_next = S_IDLE;
      round_next = 4'd0;
      col_next   = 2'd0;
    end
  end

  // Moore outputs. rcon_init is the one exception: it follows rst (and
  // abort) directly so the generator is reloaded in the same cycle.
  always_comb begin
    in_ready    = (state == S_IDLE);
    out_valid   = (state == S_DONE);
    busy        = (state == S_INIT) || (state == S_ROUND);
    rcon_init   = rst || (state == S_INIT) || abort_req;
    rcon_mask   = (state == S_ROUND) && (col_idx == 2'd0);
    // No update in the final round so rcon never runs past round NR-1.
    rcon_update = (state == S_ROUND) && (col_idx == COL_LAST) &&
                  (round_idx != ROUND_LAST);
    last_round  = (state == S_ROUND) && (round_idx == ROUND_LAST);
  end

endmodule

// File: tb/tb_aes_rcon_round_ctrl.sv
// Testbench for aes_rcon_round_ctrl: randomized and directed stimulus checked
// every cycle against a timeline model (job phase derived from cycles since
// accept) plus an rcon generator driven by the DUT's control strobes.
module tb_aes_rcon_round_ctrl;
  localparam int NR   = 10;
  localparam int CPR  = 4;
  localparam int NCYC = NR * CPR;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_inverse = 1'b0;
  logic       out_ready = 1'b1;
  logic       abort = 1'b0;
  logic       in_ready, out_valid, rcon_init, rcon_update, rcon_mask;
  logic       rcon_inverse, last_round, busy;
  logic [3:0] round_idx;
  logic [1:0] col_idx;

  aes_rcon_round_ctrl #(.NR(NR), .CPR(CPR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inverse(in_inverse), .out_valid(out_valid), .out_ready(out_ready),
`ifdef AES_RCON_CTRL_ABORT_EN
    .abort(abort),
`endif
    .rcon_init(rcon_init), .rcon_update(rcon_update), .rcon_mask(rcon_mask),
    .rcon_inverse(rcon_inverse), .round_idx(round_idx), .col_idx(col_idx),
    .last_round(last_round), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Forward AES-128 round constants, indexed by round.
  logic [7:0] tbl [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                             8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // Timeline model: mode 0 idle, 1 running (cnt 0 = INIT, 1..NCYC = ROUND), 2 done.
  int         m_mode = 0;
  int         m_cnt = 0;
  int         m_inv = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  logic [7:0] gen = 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_mode <= 0; m_cnt <= 0; m_inv <= 0;
    end else if (abort && m_mode != 0) begin
      m_mode <= 0; m_cnt <= 0;
    end else begin
      case (m_mode)
        0: if (in_valid) begin
             m_mode <= 1; m_cnt <= 0; m_inv <= int'(in_inverse); acc_cyc <= cyc + 1;
           end
        1: if (m_cnt == NCYC) m_mode <= 2; else m_cnt <= m_cnt + 1;
        2: if (out_ready) m_mode <= 0;
        default: m_mode <= 0;
      endcase
    end
    // Round-constant generator driven by the DUT's strobes.
    if (rcon_init) gen <= rcon_inverse ? 8'h36 : 8'h01;
    else if (rcon_update)
      gen <= rcon_inverse ? ((gen == 8'h1b) ? 8'h80 : (gen >> 1))
                          : ({gen[6:0], 1'b0} ^ (gen[7] ? 8'h1b : 8'h00));
  end

  int nmask = 0;
  int nupd = 0;
  int prev_mode = 0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      automatic bit rph = (m_mode == 1) && (m_cnt > 0);
      automatic int k   = m_cnt - 1;
      automatic int er  = k / CPR;
      automatic int ec  = k % CPR;
      chk("in_ready", in_ready, m_mode == 0);
      chk("out_valid", out_valid, m_mode == 2);
      chk("busy", busy, m_mode == 1);
      chk("rcon_init", rcon_init, rst || (m_mode == 1 && m_cnt == 0) || (abort && m_mode != 0));
      chk("rcon_mask", rcon_mask, rph && ec == 0);
      chk("rcon_update", rcon_update, rph && ec == CPR - 1 && er < NR - 1);
      chk("last_round", last_round, rph && er == NR - 1);
      chk("rcon_inverse", rcon_inverse, m_inv);
      if (rph) begin
        chk("round_idx", round_idx, er);
        chk("col_idx", col_idx, ec);
        if (ec == 0) chk("rcon_value", gen, (m_inv != 0) ? tbl[NR - 1 - er] : tbl[er]);
      end
      if (m_mode == 1 && m_cnt == 0) begin
        nmask <= 0; nupd <= 0;
      end else if (rph) begin
        nmask <= nmask + int'(rcon_mask);
        nupd  <= nupd + int'(rcon_update);
      end
      if (m_mode == 2 && prev_mode != 2) begin
        chk("mask_count", nmask, 10);
        chk("update_count", nupd, 9);
        chk("latency", cyc - acc_cyc + 1, 42);
      end
      prev_mode <= m_mode;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_job(input logic inv);
    in_valid = 1'b1; in_inverse = inv;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 200) begin step(); n++; end
    if (n >= 200) chk("wait_done_timeout", 0, 1);
  endtask

  task automatic wait_cnt(input int c);
    int n = 0;
    while (!(m_mode == 1 && m_cnt == c) && n < 200) begin step(); n++; end
    if (n >= 200) chk("wait_cnt_timeout", 0, 1);
  endtask

  initial begin
    int held;
    // Reset state, literal expectations.
    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rcon_init", rcon_init, 1);
    chk("rst_rcon_mask", rcon_mask, 0);
    chk("rst_rcon_update", rcon_update, 0);
    chk("rst_round_idx", round_idx, 0);
    chk("rst_col_idx", col_idx, 0);
    chk("rst_last_round", last_round, 0);
    rst = 1'b0;
    step();
    chk("idle_rcon_init", rcon_init, 0);

    // Forward and inverse jobs with out_ready held high.
    start_job(1'b0);
    chk("init_busy", busy, 1);
    chk("init_rcon_init", rcon_init, 1);
    wait_done(); step();
    start_job(1'b1);
    wait_done(); step();
    chk("idle_after_inv", in_ready, 1);

    // Backpressure: out_valid held 6 cycles.
    out_ready = 1'b0;
    start_job(1'b0);
    wait_done();
    held = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid) held++;
      if (i == 4) out_ready = 1'b1;
    end
    step();
    chk("bp_held", held, 6);
    chk("bp_released", out_valid, 0);

    // Busy rejection: in_valid during round 3 and in DONE.
    out_ready = 1'b0;
    start_job(1'b1);
    wait_cnt(1 + 3 * CPR);
    in_valid = 1'b1; in_inverse = 1'b0; step(); in_valid = 1'b0;
    wait_done();
    in_valid = 1'b1; step(); in_valid = 1'b0;
    out_ready = 1'b1;
    step(); step();
    chk("rej_idle", in_ready, 1);

    // Reset at round 5, column 2.
    start_job(1'b1);
    wait_cnt(1 + 5 * CPR + 2);
    rst = 1'b1;
    step();
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_rcon_init", rcon_init, 1);
    chk("midrst_inverse", rcon_inverse, 0);
    rst = 1'b0;
    step();
    start_job(1'b0);
    wait_done(); step();

`ifdef AES_RCON_CTRL_ABORT_EN
    // Abort at round 7, then abort together with reset.
    start_job(1'b0);
    wait_cnt(1 + 7 * CPR);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_idle", in_ready, 1);
    step();
    start_job(1'b1);
    wait_cnt(5);
    abort = 1'b1; rst = 1'b1; step(); abort = 1'b0; rst = 1'b0;
    chk("abort_rst_inverse", rcon_inverse, 0);
    step();
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 3) == 0);
      in_inverse = $urandom_range(0, 1) == 1;
      out_ready  = ($urandom_range(0, 2) != 0);
      rst        = ($urandom_range(0, 299) == 0);
`ifdef AES_RCON_CTRL_ABORT_EN
      abort      = ($urandom_range(0, 199) == 0);
`endif
      step();
    end
    rst = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
